// File: rtl/mem_64_16_rmw_ctrl.sv
// mem_64_16_rmw_ctrl: valid/ready front end for the 64x16 SRAM wrapper that turns partial writes into read-modify-write; define MEM_RMW_CTRL_STATS_EN for access counters
module mem_64_16_rmw_ctrl #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
`ifdef MEM_RMW_CTRL_STATS_EN
  output logic [15:0]     stat_rd,
  output logic [15:0]     stat_wr,
  output logic [15:0]     stat_rmw,
`endif
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int BW = DW / 8;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DATA, RMW_ISSUE, RMW_DATA, WR_ISSUE, RSP} state_t;
  state_t state, state_n;
  logic ready_n, ce_n, we_n, rvalid_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] mwdata_n, rdata_n, buf_wdata, buf_wdata_n, mask, merged;
  logic [BW-1:0] buf_be, buf_be_n;
  logic accept, full, none;
  assign accept = req_valid & req_ready;
  assign full = &req_be;
  assign none = ~|req_be;
  genvar i;
  for (i = 0; i < BW; i++) begin : g_mask
    assign mask[8*i +: 8] = {8{buf_be[i]}};
  end
  assign merged = (mem_rdata & ~mask) | (buf_wdata & mask);
  // next state and next values of every registered output
  always_comb begin
    state_n = state;
    ce_n = 1'b0;
    we_n = 1'b0;
    addr_n = mem_addr;
    mwdata_n = mem_wdata;
    rvalid_n = rsp_valid;
    rdata_n = rsp_rdata;
    buf_wdata_n = buf_wdata;
    buf_be_n = buf_be;
    case (state)
      IDLE:
        if (accept && !req_we) begin
          state_n = RD_ISSUE;
          ce_n = 1'b1;
          addr_n = req_addr;
        end else if (accept && full) begin
          state_n = WR_ISSUE;
          ce_n = 1'b1;
          we_n = 1'b1;
          addr_n = req_addr;
          mwdata_n = req_wdata;
        end else if (accept && !none) begin
          state_n = RMW_ISSUE;
          ce_n = 1'b1;
          addr_n = req_addr;
          buf_wdata_n = req_wdata;
          buf_be_n = req_be;
        end
      RD_ISSUE: state_n = RD_DATA;
      RD_DATA: begin
        state_n = RSP;
        rvalid_n = 1'b1;
        rdata_n = mem_rdata;
      end
      RMW_ISSUE: state_n = RMW_DATA;
      RMW_DATA: begin
        state_n = WR_ISSUE;
        ce_n = 1'b1;
        we_n = 1'b1;
        mwdata_n = merged;
      end
      WR_ISSUE: state_n = IDLE;
      RSP: begin
        state_n = rsp_ready ? IDLE : RSP;
        rvalid_n = ~rsp_ready;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == IDLE);
  end
  // state and output registers; ready stays low for the whole reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b0;
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      buf_wdata <= '0;
      buf_be <= '0;
    end else begin
      state <= state_n;
      req_ready <= ready_n;
      mem_ce <= ce_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= mwdata_n;
      rsp_valid <= rvalid_n;
      rsp_rdata <= rdata_n;
      buf_wdata <= buf_wdata_n;
      buf_be <= buf_be_n;
    end
  end
`ifdef MEM_RMW_CTRL_STATS_EN
  logic rd_acc, wr_acc, rmw_acc;
  assign rd_acc = accept & ~req_we;
  assign wr_acc = accept & req_we & full;
  assign rmw_acc = accept & req_we & ~full & ~none;
  // saturating accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd <= '0;
      stat_wr <= '0;
      stat_rmw <= '0;
    end else begin
      stat_rd <= stat_rd + 16'(rd_acc && stat_rd != 16'hFFFF);
      stat_wr <= stat_wr + 16'(wr_acc && stat_wr != 16'hFFFF);
      stat_rmw <= stat_rmw + 16'(rmw_acc && stat_rmw != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_mem_64_16_rmw_ctrl.sv
// tb_mem_64_16_rmw_ctrl: directed and random checks of the RMW controller against an SRAM model and a word-level reference memory
module tb_mem_64_16_rmw_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [5:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] req_be = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic mem_ce, mem_we;
  logic [5:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata = '0;
  logic [15:0] sram [64];
  logic [15:0] ref_mem [64];
  int n_chk = 0, n_fail = 0, ce_cnt = 0;
  int exp_rd = 0, exp_wr = 0, exp_rmw = 0;
`ifdef MEM_RMW_CTRL_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_rmw;
`endif

  mem_64_16_rmw_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef MEM_RMW_CTRL_STATS_EN
    .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_rmw(stat_rmw),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM wrapper model: read data appears the cycle after a read access
  always @(posedge clk) begin
    if (mem_ce) begin
      ce_cnt++;
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input logic rdy);
    chk("rst_ready", req_ready, rdy);
    chk("rst_ce_we", {mem_ce, mem_we}, 2'b00);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
  endtask

  // one request from accept to completion, checked cycle by cycle
  task automatic op(input logic we, input logic [5:0] a, input logic [15:0] d, input logic [1:0] be, input int hold);
    logic [15:0] m, exp;
    int c0;
    @(negedge clk);
    chk("ready_before", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    c0 = ce_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 6'($urandom); req_wdata = 16'($urandom); req_be = 2'($urandom);
    if (!we) begin
      exp = ref_mem[a];
      exp_rd++;
      @(negedge clk); chk("rd_c1_ce_we", {mem_ce, mem_we}, 2'b10); chk("rd_c1_addr", mem_addr, a);
      @(negedge clk); chk("rd_c2_ce_we", {mem_ce, mem_we}, 2'b00); chk("rd_c2_ready", req_ready, 0);
      @(negedge clk);
      for (int k = 0; k < hold; k++) begin
        chk("rsp_hold_valid", rsp_valid, 1); chk("rsp_hold_rdata", rsp_rdata, exp); chk("rsp_hold_ready", req_ready, 0);
        @(negedge clk);
      end
      chk("rsp_valid", rsp_valid, 1); chk("rsp_rdata", rsp_rdata, exp); chk("rsp_ready_low", req_ready, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0); chk("rsp_idle_ready", req_ready, 1);
      chk("rd_ce_pulses", ce_cnt - c0, 1);
    end else if (be == 2'b11) begin
      ref_mem[a] = d;
      exp_wr++;
      @(negedge clk); chk("wr_c1_ce_we", {mem_ce, mem_we}, 2'b11); chk("wr_c1_addr", mem_addr, a); chk("wr_c1_wdata", mem_wdata, d);
      @(negedge clk); chk("wr_c2_ce_we", {mem_ce, mem_we}, 2'b00); chk("wr_c2_ready", req_ready, 1);
      chk("wr_ce_pulses", ce_cnt - c0, 1);
    end else if (be == 2'b00) begin
      @(negedge clk); chk("nop_ce_we", {mem_ce, mem_we}, 2'b00); chk("nop_ready", req_ready, 1);
      @(negedge clk); chk("nop_ce_pulses", ce_cnt - c0, 0);
    end else begin
      for (int k = 0; k < 2; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
      exp = (ref_mem[a] & ~m) | (d & m);
      ref_mem[a] = exp;
      exp_rmw++;
      @(negedge clk); chk("rmw_c1_ce_we", {mem_ce, mem_we}, 2'b10); chk("rmw_c1_addr", mem_addr, a);
      @(negedge clk); chk("rmw_c2_ce_we", {mem_ce, mem_we}, 2'b00); chk("rmw_c2_ready", req_ready, 0);
      @(negedge clk); chk("rmw_c3_ce_we", {mem_ce, mem_we}, 2'b11); chk("rmw_c3_addr", mem_addr, a); chk("rmw_c3_wdata", mem_wdata, exp);
      @(negedge clk); chk("rmw_c4_ce_we", {mem_ce, mem_we}, 2'b00); chk("rmw_c4_ready", req_ready, 1);
      chk("rmw_ce_pulses", ce_cnt - c0, 2);
    end
  endtask

  initial begin
    int c0;
    for (int k = 0; k < 64; k++) begin
      sram[k] = 16'($urandom);
      ref_mem[k] = sram[k];
    end
    sram[63] = 16'h1234;
    ref_mem[63] = 16'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs(1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs(1'b1);
    // full write then read back
    op(1'b1, 6'h05, 16'hA5C3, 2'b11, 0);
    op(1'b0, 6'h05, 16'h0000, 2'b00, 0);
    chk("full_wr_sram", sram[5], 16'hA5C3);
    // low-byte partial write merges with stored 1234
    op(1'b1, 6'h3F, 16'hABCD, 2'b01, 0);
    op(1'b0, 6'h3F, 16'h0000, 2'b00, 0);
    chk("rmw_sram", sram[63], 16'h12CD);
    // be==0 write is a no-op
    op(1'b1, 6'h10, 16'hBEEF, 2'b00, 0);
    op(1'b0, 6'h10, 16'h0000, 2'b00, 0);
    // response back-pressure
    op(1'b0, 6'h05, 16'h0000, 2'b00, 5);
    // reset during RMW_DATA abandons the write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h07; req_wdata = 16'hFFFF; req_be = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c0 = ce_cnt;
    @(negedge clk); chk("mid_c1_ce_we", {mem_ce, mem_we}, 2'b10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); chk_reset_outs(1'b0); rst = 1'b0;
    exp_rd = 0; exp_wr = 0; exp_rmw = 0;
    @(negedge clk); chk_reset_outs(1'b1);
    chk("mid_ce_pulses", ce_cnt - c0, 1);
    chk("mid_sram", sram[7], ref_mem[7]);
    op(1'b0, 6'h07, 16'h0000, 2'b00, 0);
    // random mix
    for (int n = 0; n < 60; n++)
      op(1'($urandom), 6'($urandom), 16'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    for (int k = 0; k < 64; k++) chk("final_sram", sram[k], ref_mem[k]);
`ifdef MEM_RMW_CTRL_STATS_EN
    chk("stat_rd", stat_rd, exp_rd);
    chk("stat_wr", stat_wr, exp_wr);
    chk("stat_rmw", stat_rmw, exp_rmw);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_64_16_rmw_ctrl.md
Name: mem_64_16_rmw_ctrl

Overview:
- Initiator-side controller for the 64x16 single-port SRAM wrapper used by the riscv32i_3d caches.
- Presents a valid/ready request port with byte enables and a valid/ready read-response port.
- The macro has no usable byte mask, so partial writes are converted into read-modify-write sequences.
- Drives the wrapper's ce/we/addr/idat from registers and samples its odat.

Parameters:
- AW, 6, address width (SRAM depth 2**AW)
- DW, 16, data width; must be a multiple of 8; BW = DW/8 byte lanes

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready at rising edge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  AW  word address
- req_wdata  in  DW  write data
- req_be  in  BW  byte enables, bit i covers bits [8i+7:8i]
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  DW  read data
- mem_ce  out  1  SRAM access enable for this cycle (wrapper ce)
- mem_we  out  1  SRAM write (wrapper we); meaningful only with mem_ce
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data (wrapper idat)
- mem_rdata  in  DW  SRAM read data (wrapper odat), valid the cycle after a read access

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; req_ready=0 during reset and 1 the first cycle after; rsp_valid=0; rsp_rdata=0; mem_ce=0; mem_we=0; mem_addr=0; mem_wdata=0.
- All mem_* and rsp_* outputs are registered. req_ready = (state==IDLE) and is not combinationally dependent on req_valid.
- States: IDLE, RD_ISSUE, RD_DATA, RMW_ISSUE, RMW_DATA, WR_ISSUE, RSP.
- Timing below is relative to C0, the accept cycle.
- IDLE, accept read:
  - C1 RD_ISSUE: mem_ce=1, mem_we=0, mem_addr=req_addr.
  - C2 RD_DATA: mem_ce=0; capture mem_rdata into rsp_rdata at the end of C2.
  - C3 RSP: rsp_valid=1.
  - Read latency: accept to rsp_valid = 3 cycles.
- IDLE, accept write with req_be all ones:
  - C1 WR_ISSUE: mem_ce=1, mem_we=1, mem_addr and mem_wdata = request values.
  - C2 IDLE.
- IDLE, accept write with partial req_be (nonzero, not all ones):
  - C1 RMW_ISSUE: read access.
  - C2 RMW_DATA: merged = (mem_rdata & ~mask) | (wdata & mask), where mask expands each be bit to 8 bits.
  - C3 WR_ISSUE: write merged data.
  - C4 IDLE.
- Write with req_be==0: accepted as a no-op. No mem_ce; stays in IDLE; req_ready stays 1.
- RSP state:
  - rsp_valid holds 1 and rsp_rdata holds stable until rsp_ready=1.
  - Return to IDLE the cycle after the handshake; rsp_valid drops to 0 there.
  - req_ready=0 while in RSP.
- Writes never produce a response.
- mem_ce is high for exactly one cycle per access. mem_we=0 whenever mem_ce=0. mem_addr and mem_wdata hold their last values when idle.
- Request fields are latched at accept; input changes after accept have no effect.
- Ordering: one outstanding operation only; a read after a write to the same address returns the written data.
- Reset mid-operation: in-flight RMW or read is abandoned, no write is issued, and all outputs take their reset values next cycle.
- Address wraps naturally within AW bits; there is no range check.

Optional Feature:
- Macro: MEM_RMW_CTRL_STATS_EN.
- With the macro: adds outputs stat_rd, stat_wr, stat_rmw, each 16 bits, saturating at 16'hFFFF.
  - stat_rd increments once per read accept.
  - stat_wr increments once per full-mask write accept.
  - stat_rmw increments once per partial-mask write accept.
  - be==0 writes are not counted.
  - All three clear on rst.
- Without the macro: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset, then full write addr 6'h05 data 16'hA5C3 be=2'b11, then read 6'h05 -> exactly one mem_ce/mem_we pulse in cycle C1; read rsp_valid in C3 with rsp_rdata=16'hA5C3.
- Mem holds 16'h1234 at 6'h3F; write 16'hABCD be=2'b01 -> read at C1, write at C3 with mem_wdata=16'h12CD; req_ready back to 1 at C4; read returns 16'h12CD.
- Write be=2'b00 to 6'h10 -> no mem_ce at any cycle; req_ready stays 1; a following read of 6'h10 returns the prior contents unchanged.
- Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable; req_ready=0 throughout; IDLE the cycle after rsp_ready=1.
- Assert rst during RMW_DATA of write 16'hFFFF be=2'b10 -> no write access issued; all outputs 0 next cycle; memory word unchanged.
- With MEM_RMW_CTRL_STATS_EN: 3 reads, 2 full writes, 1 partial write, 1 be==0 write -> stat_rd=3, stat_wr=2, stat_rmw=1; then force the count past 65535 -> stat_rd saturates at 16'hFFFF.
